// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared defaults, derived sizes and FSM encoding for the conv2d feeder.
`default_nettype none

package conv2d_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_IMG_W  = 32;
    localparam int DEF_IMG_H  = 32;
    localparam int DEF_K      = 5;

    localparam int KWORDS = DEF_K * DEF_K;
    localparam int NPIX   = DEF_IMG_W * DEF_IMG_H;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KLOAD  = 3'd1,
        KWAIT  = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/conv2d_feeder_if.sv
// conv2d_feeder_if: memory-side and conv2d-side signals of the feeder.
// CONV2D_FEEDER_STALL_EN adds the stall input.
`default_nettype none

interface conv2d_feeder_if #(
    parameter int DATA_W = 32,
    parameter int IMG_AW = 10,
    parameter int KER_AW = 5
);
    logic              start;
`ifdef CONV2D_FEEDER_STALL_EN
    logic              stall;
`endif
    logic              ker_rd_en;
    logic [KER_AW-1:0] ker_addr;
    logic [DATA_W-1:0] ker_rd_data;
    logic              img_rd_en;
    logic [IMG_AW-1:0] img_addr;
    logic [DATA_W-1:0] img_rd_data;
    logic              load_kernel;
    logic [DATA_W-1:0] kernel;
    logic              load_kernel_done;
    logic              data_valid_in;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;

    modport master (
        input  start,
`ifdef CONV2D_FEEDER_STALL_EN
        input  stall,
`endif
        input  ker_rd_data, img_rd_data, load_kernel_done,
        output ker_rd_en, ker_addr, img_rd_en, img_addr,
        output load_kernel, kernel, data_valid_in, data_in, busy, done
    );

    modport slave (
        output start,
`ifdef CONV2D_FEEDER_STALL_EN
        output stall,
`endif
        output ker_rd_data, img_rd_data, load_kernel_done,
        input  ker_rd_en, ker_addr, img_rd_en, img_addr,
        input  load_kernel, kernel, data_valid_in, data_in, busy, done
    );

endinterface

`default_nettype wire

// File: rtl/conv2d_feeder_rdpipe.sv
// conv2d_feeder_rdpipe: aligns a 1-cycle-latency memory read with its valid strobe.
`default_nettype none

module conv2d_feeder_rdpipe #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else begin
            valid <= rd_en;
        end
    end

    // Memory output is stale between reads, so it is forced to zero when not valid.
    assign data = valid ? rd_data : '0;

endmodule

`default_nettype wire

// File: rtl/conv2d_feeder.sv
// conv2d_feeder: loads a KxK kernel then streams an image into conv2d from BRAM.
// CONV2D_FEEDER_STALL_EN enables the stream stall input.
`default_nettype none

module conv2d_feeder
    import conv2d_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int IMG_AW = 10,
    parameter int KER_AW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    conv2d_feeder_if.master bus
);

    localparam int KER_WORDS = K * K;
    localparam int PIX_WORDS = IMG_W * IMG_H;
    localparam logic [KER_AW-1:0] KER_LAST = KER_AW'(KER_WORDS - 1);
    localparam logic [IMG_AW-1:0] PIX_LAST = IMG_AW'(PIX_WORDS - 1);

    state_t            state, state_nxt;
    logic [KER_AW-1:0] kcnt, kcnt_nxt;
    logic [IMG_AW-1:0] pcnt, pcnt_nxt;
    logic              done_q;
    logic              ker_rd_en, img_rd_en;
    logic              ker_valid, img_valid;
    logic              issue_ok;

`ifdef CONV2D_FEEDER_STALL_EN
    assign issue_ok = ~bus.stall;
`else
    assign issue_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            kcnt   <= '0;
            pcnt   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            kcnt   <= kcnt_nxt;
            pcnt   <= pcnt_nxt;
            done_q <= (state == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        kcnt_nxt  = kcnt;
        pcnt_nxt  = pcnt;
        ker_rd_en = 1'b0;
        img_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = KLOAD;
                    kcnt_nxt  = '0;
                end
            end
            KLOAD: begin
                ker_rd_en = 1'b1;
                if (kcnt == KER_LAST) begin
                    state_nxt = KWAIT;
                end else begin
                    kcnt_nxt = kcnt + 1'b1;
                end
            end
            KWAIT: begin
                // The last kernel word is still on the bus during the first KWAIT
                // cycle; the acknowledge only counts once it has gone out.
                if (!ker_valid && bus.load_kernel_done) begin
                    state_nxt = STREAM;
                    pcnt_nxt  = '0;
                end
            end
            STREAM: begin
                if (issue_ok) begin
                    img_rd_en = 1'b1;
                    if (pcnt == PIX_LAST) begin
                        state_nxt = DONE;
                    end else begin
                        pcnt_nxt = pcnt + 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    conv2d_feeder_rdpipe #(.DATA_W(DATA_W)) u_ker_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (ker_rd_en),
        .rd_data (bus.ker_rd_data),
        .valid   (ker_valid),
        .data    (bus.kernel)
    );

    conv2d_feeder_rdpipe #(.DATA_W(DATA_W)) u_img_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (img_rd_en),
        .rd_data (bus.img_rd_data),
        .valid   (img_valid),
        .data    (bus.data_in)
    );

    assign bus.ker_rd_en     = ker_rd_en;
    assign bus.ker_addr      = (state == KLOAD)  ? kcnt : '0;
    assign bus.img_rd_en     = img_rd_en;
    assign bus.img_addr      = (state == STREAM) ? pcnt : '0;
    assign bus.load_kernel   = ker_valid;
    assign bus.data_valid_in = img_valid;
    assign bus.busy          = (state != IDLE);
    assign bus.done          = done_q;

endmodule

`default_nettype wire

// File: tb/tb_conv2d_feeder.sv
// tb_conv2d_feeder: directed scenario table plus reset/stall sequences for conv2d_feeder.
`default_nettype none

module tb_conv2d_feeder;
    import conv2d_pkg::*;

    localparam int KW = KWORDS;
    localparam int NP = NPIX;

    typedef struct {
        string name;
        int    ack_delay;
        bit    early_ack;
        int    start_at;
        int    stall_at;
        int    exp_kw;
        int    exp_pix;
        int    exp_dones;
        int    exp_runs;
        int    exp_gap;
    } vec_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;

    conv2d_feeder_if #(.DATA_W(32), .IMG_AW(10), .KER_AW(5)) bus ();

    conv2d_feeder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] kval(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    function automatic logic [31:0] pval(input int i);
        return 32'h5A00_0000 | (32'(i) * 32'd3);
    endfunction

    // Synchronous-read memories with one cycle of latency.
    always @(posedge clk) begin
        if (bus.ker_rd_en) bus.ker_rd_data <= kval(int'(bus.ker_addr));
        if (bus.img_rd_en) bus.img_rd_data <= pval(int'(bus.img_addr));
    end

    // Observer state, cleared on request from the stimulus process.
    logic mon_clr;
    int   kidx, pidx, kbad, pbad, addr_bad, kruns, pruns, pgap, dones;
    int   kaddr_exp, paddr_exp, first_lk, first_dv, last_dv, done_cyc;
    logic lk_prev, dv_prev;

    always @(negedge clk) begin
        if (mon_clr) begin
            kidx = 0; pidx = 0; kbad = 0; pbad = 0; addr_bad = 0;
            kruns = 0; pruns = 0; pgap = 0; dones = 0;
            kaddr_exp = 0; paddr_exp = 0;
            first_lk = -1; first_dv = -1; last_dv = -1; done_cyc = -1;
            lk_prev = 1'b0; dv_prev = 1'b0;
        end else begin
            if (bus.ker_rd_en) begin
                if (int'(bus.ker_addr) != kaddr_exp) addr_bad++;
                kaddr_exp++;
            end
            if (bus.img_rd_en) begin
                if (int'(bus.img_addr) != paddr_exp) addr_bad++;
                paddr_exp++;
            end
            if (bus.load_kernel) begin
                if (kidx == 0) first_lk = cyc;
                if (bus.kernel != kval(kidx)) kbad++;
                if (!lk_prev) kruns++;
                kidx++;
            end else if (bus.kernel != 32'd0) begin
                kbad++;
            end
            if (bus.data_valid_in) begin
                if (pidx == 0) first_dv = cyc;
                if (bus.data_in != pval(pidx)) pbad++;
                if (!dv_prev) pruns++;
                last_dv = cyc;
                pidx++;
            end else begin
                if (bus.data_in != 32'd0) pbad++;
                if (pidx > 0 && pidx < NP) pgap++;
            end
            if (bus.done) begin
                dones++;
                done_cyc = cyc;
            end
            lk_prev = bus.load_kernel;
            dv_prev = bus.data_valid_in;
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [127:0] all_outs();
        return {bus.ker_rd_en, bus.ker_addr, bus.img_rd_en, bus.img_addr,
                bus.load_kernel, bus.kernel, bus.data_valid_in, bus.data_in,
                bus.busy, bus.done};
    endfunction

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic kick_and_load(output int sc);
        int n;
        sc = cyc;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (!(kidx == KW && !bus.load_kernel) && n < 200) begin
            step();
            n++;
        end
        chk("kernel_phase_bound", (n < 200), 1);
    endtask

    task automatic wait_pix(input int target);
        int n;
        n = 0;
        while (pidx < target && n < 3000) begin
            step();
            n++;
        end
        chk("pixel_wait_bound", (n < 3000), 1);
    endtask

    task automatic run_scn(input vec_t v);
        int sc, dc, n, hold_bad;
        clear_mon();
        sc = cyc;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (v.early_ack) begin
            repeat (5) step();
            bus.load_kernel_done = 1'b1;
            step();
            bus.load_kernel_done = 1'b0;
        end
        n = 0;
        while (!(kidx == KW && !bus.load_kernel) && n < 200) begin
            step();
            n++;
        end
        chk({v.name, ":kernel_bound"}, (n < 200), 1);
        chk({v.name, ":first_load_kernel_cycle"}, first_lk, sc + 2);
        chk({v.name, ":no_pixels_during_kload"}, pidx, 0);
        hold_bad = 0;
        for (int i = 0; i < v.ack_delay; i++) begin
            if (!bus.busy || bus.img_rd_en || bus.data_valid_in) hold_bad++;
            step();
        end
        chk({v.name, ":kwait_hold"}, hold_bad, 0);
        dc = cyc;
        bus.load_kernel_done = 1'b1;
        step();
        bus.load_kernel_done = 1'b0;
        if (v.start_at >= 0) begin
            wait_pix(v.start_at);
            bus.start = 1'b1;
            step();
            bus.start = 1'b0;
        end
`ifdef CONV2D_FEEDER_STALL_EN
        if (v.stall_at >= 0) begin
            wait_pix(v.stall_at);
            bus.stall = 1'b1;
            repeat (3) step();
            bus.stall = 1'b0;
        end
`endif
        n = 0;
        while (dones < 1 && n < 3000) begin
            step();
            n++;
        end
        chk({v.name, ":done_bound"}, (n < 3000), 1);
        repeat (5) step();
        chk({v.name, ":first_data_valid_cycle"}, first_dv, dc + 2);
        chk({v.name, ":kernel_words"}, kidx, v.exp_kw);
        chk({v.name, ":kernel_content_errs"}, kbad, 0);
        chk({v.name, ":kernel_runs"}, kruns, 1);
        chk({v.name, ":pixels"}, pidx, v.exp_pix);
        chk({v.name, ":pixel_content_errs"}, pbad, 0);
        chk({v.name, ":address_errs"}, addr_bad, 0);
        chk({v.name, ":pixel_runs"}, pruns, v.exp_runs);
        chk({v.name, ":pixel_gap_cycles"}, pgap, v.exp_gap);
        chk({v.name, ":done_count"}, dones, v.exp_dones);
        chk({v.name, ":done_after_last_valid"}, done_cyc - last_dv, 1);
        chk({v.name, ":done_from_first_valid"}, done_cyc - first_dv, v.exp_pix + v.exp_gap);
        chk({v.name, ":idle_after"}, bus.busy, 0);
    endtask

    vec_t vecs[$];

    initial begin
        int sc;
        checks = 0;
        errors = 0;
        cyc = 0;
        mon_clr = 1'b1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.load_kernel_done = 1'b0;
`ifdef CONV2D_FEEDER_STALL_EN
        bus.stall = 1'b0;
`endif

        vecs.push_back('{"basic",     0,  1'b0, -1,  -1, KW, NP, 1, 1, 0});
        vecs.push_back('{"ack_delay", 10, 1'b0, -1,  -1, KW, NP, 1, 1, 0});
        vecs.push_back('{"early_ack", 3,  1'b1, -1,  -1, KW, NP, 1, 1, 0});
        vecs.push_back('{"start_mid", 0,  1'b0, 300, -1, KW, NP, 1, 1, 0});
`ifdef CONV2D_FEEDER_STALL_EN
        vecs.push_back('{"stall3",    0,  1'b0, -1, 100, KW, NP, 1, 2, 3});
`endif

        repeat (3) step();
        chk("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        mon_clr = 1'b0;
        repeat (5) step();
        chk("idle_no_start_busy", bus.busy, 0);
        chk("idle_no_start_kread", kruns, 0);

        foreach (vecs[i]) run_scn(vecs[i]);

        // Abort in the middle of the stream, then a full clean run must follow.
        clear_mon();
        kick_and_load(sc);
        bus.load_kernel_done = 1'b1;
        step();
        bus.load_kernel_done = 1'b0;
        wait_pix(500);
        #1 rst_n = 1'b0;
        #1 chk("midreset_outputs", all_outs(), 0);
        repeat (3) step();
        chk("midreset_no_done", dones, 0);
        chk("midreset_idle", bus.busy, 0);
        rst_n = 1'b1;
        step();
        run_scn(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
